// File: rtl/product_accumulator_pkg.sv
// Shared types for the product accumulator and other consumers
// of the 16x16 multiplier's product stream.
package product_accumulator_pkg;

   localparam int PROD_W = 32;
   localparam int RES_CNT_W = 32;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } state_e;

   typedef struct packed {
      logic [PROD_W-1:0]    sum;
      logic [RES_CNT_W-1:0] count;
      logic                 overflow;
   } result_t;

endpackage

// File: rtl/product_accumulator_if.sv
// Product-in and result-out valid/ready streams of the accumulator.
interface product_accumulator_if
   import product_accumulator_pkg::*;
#(
   parameter int COUNT_WIDTH = 8
);

   logic                   in_valid;
   logic                   in_ready;
   logic [PROD_W-1:0]      in_product;
   logic                   in_last;
   logic                   out_valid;
   logic                   out_ready;
   logic [PROD_W-1:0]      out_sum;
   logic [COUNT_WIDTH-1:0] out_count;
   logic                   out_overflow;

   modport master (
      output in_valid, in_product, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_count, out_overflow
   );

   modport slave (
      input  in_valid, in_product, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_count, out_overflow
   );

endinterface

// File: rtl/product_accumulator_core.sv
// Next-state datapath: wrapping adder with carry detect and a
// saturating beat counter; saturation also flags overflow.
module product_accumulator_core
   import product_accumulator_pkg::*;
#(
   parameter int COUNT_WIDTH = 8
) (
   input  logic [PROD_W-1:0]      sum_i,
   input  logic [COUNT_WIDTH-1:0] cnt_i,
   input  logic                   ovf_i,
   input  logic [PROD_W-1:0]      product_i,
   output logic [PROD_W-1:0]      sum_o,
   output logic [COUNT_WIDTH-1:0] cnt_o,
   output logic                   ovf_o
);

   logic [PROD_W:0] ext_sum;
   logic            cnt_max;

   assign ext_sum = {1'b0, sum_i} + {1'b0, product_i};
   assign cnt_max = &cnt_i;

   assign sum_o = ext_sum[PROD_W-1:0];
   assign cnt_o = cnt_max ? cnt_i : cnt_i + COUNT_WIDTH'(1);
   assign ovf_o = ovf_i | ext_sum[PROD_W] | cnt_max;

endmodule

// File: rtl/product_accumulator.sv
// Group accumulator: sums product beats up to a last marker and
// holds the result in an output register separate from the sum.
module product_accumulator
   import product_accumulator_pkg::*;
#(
   parameter int COUNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   product_accumulator_if.slave bus,
   output logic                 busy
);

   state_e                 state_q;
   logic [PROD_W-1:0]      acc_sum_q, acc_sum_d;
   logic [COUNT_WIDTH-1:0] acc_cnt_q, acc_cnt_d;
   logic                   acc_ovf_q, acc_ovf_d;
   logic [PROD_W-1:0]      out_sum_q;
   logic [COUNT_WIDTH-1:0] out_cnt_q;
   logic                   out_ovf_q;
   logic                   out_valid_q;
   logic                   in_ready;
   logic                   accept;

   product_accumulator_core #(
      .COUNT_WIDTH (COUNT_WIDTH)
   ) u_core (
      .sum_i     (acc_sum_q),
      .cnt_i     (acc_cnt_q),
      .ovf_i     (acc_ovf_q),
      .product_i (bus.in_product),
      .sum_o     (acc_sum_d),
      .cnt_o     (acc_cnt_d),
      .ovf_o     (acc_ovf_d)
   );

   // A held result blocks every beat, last or not.
   assign in_ready = !(out_valid_q && !bus.out_ready);
   assign accept   = bus.in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         acc_sum_q   <= '0;
         acc_cnt_q   <= '0;
         acc_ovf_q   <= 1'b0;
         out_sum_q   <= '0;
         out_cnt_q   <= '0;
         out_ovf_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         if (bus.out_ready) out_valid_q <= 1'b0;
         if (clear) begin
            state_q   <= ST_IDLE;
            acc_sum_q <= '0;
            acc_cnt_q <= '0;
            acc_ovf_q <= 1'b0;
         end else if (accept) begin
            if (bus.in_last) begin
               out_sum_q   <= acc_sum_d;
               out_cnt_q   <= acc_cnt_d;
               out_ovf_q   <= acc_ovf_d;
               out_valid_q <= 1'b1;
               state_q     <= ST_IDLE;
               acc_sum_q   <= '0;
               acc_cnt_q   <= '0;
               acc_ovf_q   <= 1'b0;
            end else begin
               state_q   <= ST_ACCUM;
               acc_sum_q <= acc_sum_d;
               acc_cnt_q <= acc_cnt_d;
               acc_ovf_q <= acc_ovf_d;
            end
         end
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_sum      = out_sum_q;
   assign bus.out_count    = out_cnt_q;
   assign bus.out_overflow = out_ovf_q;
   assign busy             = (state_q == ST_ACCUM);

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: an 8-bit-count instance
// for the main features and a 2-bit-count instance for saturation.
module tb_product_accumulator;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic clear = 1'b0;
   logic busy_a, busy_s;
   int   total = 0;
   int   bad = 0;

   product_accumulator_if #(.COUNT_WIDTH(8)) a_if ();
   product_accumulator_if #(.COUNT_WIDTH(2)) s_if ();

   product_accumulator #(.COUNT_WIDTH(8)) u_dut (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .bus   (a_if.slave),
      .busy  (busy_a)
   );

   product_accumulator #(.COUNT_WIDTH(2)) u_sat (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .bus   (s_if.slave),
      .busy  (busy_s)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one beat on the main instance and return 1 time unit
   // after the edge on which it was accepted.
   task automatic beat_a(input logic [31:0] p, input logic l);
      bit done = 0;
      a_if.in_valid   = 1'b1;
      a_if.in_product = p;
      a_if.in_last    = l;
      for (int i = 0; i < 20 && !done; i++) begin
         done = (a_if.in_ready === 1'b1);
         tick();
      end
      a_if.in_valid = 1'b0;
      a_if.in_last  = 1'b0;
      if (!done) begin
         total++;
         bad++;
         $display("FAIL beat_a_timeout product=%0h never accepted", p);
      end
   endtask

   task automatic beat_s(input logic [31:0] p, input logic l);
      bit done = 0;
      s_if.in_valid   = 1'b1;
      s_if.in_product = p;
      s_if.in_last    = l;
      for (int i = 0; i < 20 && !done; i++) begin
         done = (s_if.in_ready === 1'b1);
         tick();
      end
      s_if.in_valid = 1'b0;
      s_if.in_last  = 1'b0;
      if (!done) begin
         total++;
         bad++;
         $display("FAIL beat_s_timeout product=%0h never accepted", p);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      tick();
      total++; if (a_if.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", a_if.out_valid); end
      total++; if (a_if.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b want=1", a_if.in_ready); end
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy_a); end
      total++; if (a_if.out_sum !== 32'd0) begin bad++; $display("FAIL rst_out_sum got=%0h want=0", a_if.out_sum); end
      total++; if (a_if.out_count !== 8'd0) begin bad++; $display("FAIL rst_out_count got=%0d want=0", a_if.out_count); end
      total++; if (a_if.out_overflow !== 1'b0) begin bad++; $display("FAIL rst_out_ovf got=%0b want=0", a_if.out_overflow); end
      total++; if (s_if.out_valid !== 1'b0) begin bad++; $display("FAIL rst_s_out_valid got=%0b want=0", s_if.out_valid); end
   endtask

   task automatic test_basic();
      a_if.out_ready = 1'b1;
      beat_a(32'd3, 1'b0);
      total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL basic_busy_open got=%0b want=1", busy_a); end
      total++; if (a_if.out_valid !== 1'b0) begin bad++; $display("FAIL basic_no_early_out got=%0b want=0", a_if.out_valid); end
      beat_a(32'd5, 1'b0);
      beat_a(32'd7, 1'b1);
      total++; if (a_if.out_valid !== 1'b1) begin bad++; $display("FAIL basic_out_valid got=%0b want=1", a_if.out_valid); end
      total++; if (a_if.out_sum !== 32'd15) begin bad++; $display("FAIL basic_sum got=%0d want=15", a_if.out_sum); end
      total++; if (a_if.out_count !== 8'd3) begin bad++; $display("FAIL basic_count got=%0d want=3", a_if.out_count); end
      total++; if (a_if.out_overflow !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%0b want=0", a_if.out_overflow); end
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%0b want=0", busy_a); end
      tick();
      total++; if (a_if.out_valid !== 1'b0) begin bad++; $display("FAIL basic_consumed got=%0b want=0", a_if.out_valid); end
   endtask

   task automatic test_overflow();
      a_if.out_ready = 1'b1;
      beat_a(32'hFFFE0001, 1'b0);
      beat_a(32'hFFFE0001, 1'b1);
      total++; if (a_if.out_sum !== 32'hFFFC0002) begin bad++; $display("FAIL ovf_sum got=%0h want=fffc0002", a_if.out_sum); end
      total++; if (a_if.out_count !== 8'd2) begin bad++; $display("FAIL ovf_count got=%0d want=2", a_if.out_count); end
      total++; if (a_if.out_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b want=1", a_if.out_overflow); end
      beat_a(32'd42, 1'b1);
      total++; if (a_if.out_sum !== 32'd42) begin bad++; $display("FAIL single_sum got=%0d want=42", a_if.out_sum); end
      total++; if (a_if.out_count !== 8'd1) begin bad++; $display("FAIL single_count got=%0d want=1", a_if.out_count); end
      total++; if (a_if.out_overflow !== 1'b0) begin bad++; $display("FAIL single_ovf_cleared got=%0b want=0", a_if.out_overflow); end
      tick();
   endtask

   task automatic test_backpressure();
      a_if.out_ready = 1'b0;
      beat_a(32'd9, 1'b1);
      a_if.in_valid   = 1'b1;
      a_if.in_product = 32'd1;
      a_if.in_last    = 1'b0;
      repeat (3) tick();
      total++; if (a_if.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%0b want=0", a_if.in_ready); end
      total++; if (a_if.out_valid !== 1'b1) begin bad++; $display("FAIL bp_held_valid got=%0b want=1", a_if.out_valid); end
      total++; if (a_if.out_sum !== 32'd9) begin bad++; $display("FAIL bp_held_sum got=%0d want=9", a_if.out_sum); end
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL bp_no_accept got=%0b want=0", busy_a); end
      a_if.out_ready = 1'b1;
      #1;
      total++; if (a_if.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%0b want=1", a_if.in_ready); end
      beat_a(32'd1, 1'b0);
      total++; if (a_if.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%0b want=0", a_if.out_valid); end
      beat_a(32'd2, 1'b0);
      beat_a(32'd4, 1'b1);
      total++; if (a_if.out_sum !== 32'd7) begin bad++; $display("FAIL bp_next_sum got=%0d want=7", a_if.out_sum); end
      total++; if (a_if.out_count !== 8'd3) begin bad++; $display("FAIL bp_next_count got=%0d want=3", a_if.out_count); end
      tick();
   endtask

   task automatic test_clear();
      a_if.out_ready = 1'b1;
      beat_a(32'd10, 1'b0);
      clear           = 1'b1;
      a_if.in_valid   = 1'b1;
      a_if.in_product = 32'd99;
      a_if.in_last    = 1'b0;
      tick();
      clear         = 1'b0;
      a_if.in_valid = 1'b0;
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL clr_busy got=%0b want=0", busy_a); end
      beat_a(32'd20, 1'b1);
      total++; if (a_if.out_sum !== 32'd20) begin bad++; $display("FAIL clr_sum got=%0d want=20", a_if.out_sum); end
      total++; if (a_if.out_count !== 8'd1) begin bad++; $display("FAIL clr_count got=%0d want=1", a_if.out_count); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [3] = '{32'd11, 32'd12, 32'd13};
      a_if.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         beat_a(vals[i], 1'b1);
         total++; if (a_if.out_valid !== 1'b1 || a_if.out_sum !== vals[i]) begin bad++; $display("FAIL b2b_%0d got v=%0b s=%0d want v=1 s=%0d", i, a_if.out_valid, a_if.out_sum, vals[i]); end
      end
      tick();
   endtask

   task automatic test_saturation();
      s_if.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) beat_s(32'd1, 1'b0);
      beat_s(32'd1, 1'b1);
      total++; if (s_if.out_count !== 2'd3) begin bad++; $display("FAIL sat_count got=%0d want=3", s_if.out_count); end
      total++; if (s_if.out_sum !== 32'd5) begin bad++; $display("FAIL sat_sum got=%0d want=5", s_if.out_sum); end
      total++; if (s_if.out_overflow !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%0b want=1", s_if.out_overflow); end
      tick();
      beat_s(32'd1, 1'b0);
      beat_s(32'd1, 1'b0);
      total++; if (busy_s !== 1'b1) begin bad++; $display("FAIL sat_busy_mid got=%0b want=1", busy_s); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (3) tick();
      total++; if (busy_s !== 1'b0) begin bad++; $display("FAIL sat_rst_busy got=%0b want=0", busy_s); end
      total++; if (s_if.out_valid !== 1'b0) begin bad++; $display("FAIL sat_rst_no_out got=%0b want=0", s_if.out_valid); end
      beat_s(32'd6, 1'b1);
      total++; if (s_if.out_sum !== 32'd6 || s_if.out_count !== 2'd1 || s_if.out_overflow !== 1'b0) begin bad++; $display("FAIL sat_after_rst got s=%0d c=%0d o=%0b want s=6 c=1 o=0", s_if.out_sum, s_if.out_count, s_if.out_overflow); end
   endtask

   initial begin
      a_if.in_valid   = 1'b0;
      a_if.in_product = '0;
      a_if.in_last    = 1'b0;
      a_if.out_ready  = 1'b0;
      s_if.in_valid   = 1'b0;
      s_if.in_product = '0;
      s_if.in_last    = 1'b0;
      s_if.out_ready  = 1'b0;
      test_reset();
      test_basic();
      test_overflow();
      test_backpressure();
      test_clear();
      test_back_to_back();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
